// File: rtl/bsg_print_stat_timestamp_fifo.sv
// Timestamping event FIFO for the print-stat snoop: stamps each captured tag with
// the global cycle count, buffers it, and counts events lost to overflow.
module bsg_print_stat_timestamp_fifo #(
    parameter int unsigned data_width_p = 32,
    parameter int unsigned ctr_width_p  = 64,
    parameter int unsigned els_p        = 16,
    parameter int unsigned drop_width_p = 16
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 en_i,
    input  logic                                 clear_i,
    input  logic                                 print_stat_v_i,
    input  logic [data_width_p-1:0]              print_stat_tag_i,
    input  logic [ctr_width_p-1:0]               global_ctr_i,
    output logic                                 v_o,
    output logic [ctr_width_p+data_width_p-1:0]  data_o,
    input  logic                                 yumi_i,
    output logic [$clog2(els_p+1)-1:0]           count_o,
    output logic [drop_width_p-1:0]              drop_count_o,
    output logic                                 overflow_o
);

    localparam int unsigned entry_w = ctr_width_p + data_width_p;
    localparam int unsigned addr_w  = $clog2(els_p);
    localparam int unsigned ptr_w   = addr_w + 1;
    localparam int unsigned cnt_w   = $clog2(els_p + 1);

    logic [entry_w-1:0]      mem [els_p];
    logic [ptr_w-1:0]        wr_ptr_r, wr_ptr_n;
    logic [ptr_w-1:0]        rd_ptr_r, rd_ptr_n;
    logic [cnt_w-1:0]        count_r, count_n;
    logic [drop_width_p-1:0] drop_r, drop_n;
    logic                    ovf_r, ovf_n;
    logic                    v_r, v_n;
    logic [entry_w-1:0]      data_r, data_n;
    logic [entry_w-1:0]      wdata;
    logic                    full, pop, wr_try, wr_ok, drop;

    assign wdata  = {global_ctr_i, print_stat_tag_i};
    assign full   = (wr_ptr_r[addr_w] != rd_ptr_r[addr_w])
                 && (wr_ptr_r[addr_w-1:0] == rd_ptr_r[addr_w-1:0]);
    // Pops while empty are illegal and simply ignored.
    assign pop    = yumi_i & v_r;
    // A write on a clear cycle is discarded outright, never counted as a drop.
    assign wr_try = en_i & print_stat_v_i & ~clear_i;
    assign wr_ok  = wr_try & (~full | pop);
    assign drop   = wr_try & ~wr_ok;

    // Next-state for pointers, occupancy, stats and the registered head view.
    always_comb begin
        wr_ptr_n = wr_ptr_r;
        rd_ptr_n = rd_ptr_r;
        count_n  = count_r;
        drop_n   = drop_r;
        ovf_n    = ovf_r;
        if (clear_i) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
            drop_n   = '0;
            ovf_n    = 1'b0;
        end else begin
            if (wr_ok) wr_ptr_n = wr_ptr_r + ptr_w'(1);
            if (pop)   rd_ptr_n = rd_ptr_r + ptr_w'(1);
            count_n = count_r + cnt_w'(wr_ok) - cnt_w'(pop);
            if (drop) begin
                ovf_n = 1'b1;
                if (drop_r != '1) drop_n = drop_r + drop_width_p'(1);
            end
        end
        v_n = (rd_ptr_n != wr_ptr_n);
        // The slot being written becomes the head only when it is the sole entry.
        if (wr_ok && (wr_ptr_r[addr_w-1:0] == rd_ptr_n[addr_w-1:0]))
            data_n = wdata;
        else
            data_n = mem[rd_ptr_n[addr_w-1:0]];
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wr_ptr_r[addr_w-1:0]] <= wdata;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            drop_r   <= '0;
            ovf_r    <= 1'b0;
            v_r      <= 1'b0;
            data_r   <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_n;
            rd_ptr_r <= rd_ptr_n;
            count_r  <= count_n;
            drop_r   <= drop_n;
            ovf_r    <= ovf_n;
            v_r      <= v_n;
            data_r   <= data_n;
        end
    end

    assign v_o          = v_r;
    assign data_o       = data_r;
    assign count_o      = count_r;
    assign drop_count_o = drop_r;
    assign overflow_o   = ovf_r;

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(yumi_i && !v_o));

endmodule

// File: tb/tb_bsg_print_stat_timestamp_fifo.sv
// Bench for the timestamp FIFO: vector table, directed corner sequences and a
// randomized run against a queue-based model; a second instance uses a 2-bit drop counter.
module tb_bsg_print_stat_timestamp_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, clr, sv, yumi;
    logic [31:0] tag;
    logic [63:0] ctr;

    logic        v_a, ovf_a, v_b, ovf_b;
    logic [95:0] data_a, data_b;
    logic [4:0]  count_a, count_b;
    logic [15:0] drop_a;
    logic [1:0]  drop_b;

    always #5 clk = ~clk;

    bsg_print_stat_timestamp_fifo dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .clear_i(clr),
        .print_stat_v_i(sv), .print_stat_tag_i(tag), .global_ctr_i(ctr),
        .v_o(v_a), .data_o(data_a), .yumi_i(yumi), .count_o(count_a),
        .drop_count_o(drop_a), .overflow_o(ovf_a)
    );

    bsg_print_stat_timestamp_fifo #(.drop_width_p(2)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .clear_i(clr),
        .print_stat_v_i(sv), .print_stat_tag_i(tag), .global_ctr_i(ctr),
        .v_o(v_b), .data_o(data_b), .yumi_i(yumi), .count_o(count_b),
        .drop_count_o(drop_b), .overflow_o(ovf_b)
    );

    // Reference model: ordered queue of {timestamp, tag}, unbounded drop tally.
    logic [95:0] q[$];
    int unsigned drops;
    bit          ovf;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct {
        logic        en, v;
        logic [31:0] tag;
        logic        y, clr;
        logic        exp_v;
        logic [4:0]  exp_cnt;
        logic [15:0] exp_drop;
        logic        chk_data;
        logic [95:0] exp_data;
    } vec_t;

    vec_t tbl[9];

    function automatic vec_t mk(input logic e, input logic v, input logic [31:0] t,
                                input logic y, input logic c, input logic ev,
                                input logic [4:0] ec, input logic [15:0] ed,
                                input logic cd, input logic [95:0] edata);
        vec_t r;
        r.en = e; r.v = v; r.tag = t; r.y = y; r.clr = c;
        r.exp_v = ev; r.exp_cnt = ec; r.exp_drop = ed;
        r.chk_data = cd; r.exp_data = edata;
        return r;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model();
        logic [15:0] ea;
        logic [1:0]  eb;
        ea = (drops > 65535) ? 16'hFFFF : 16'(drops);
        eb = (drops > 3) ? 2'd3 : 2'(drops);
        chk("m_v_a",     {95'd0, v_a},   {95'd0, q.size() > 0});
        chk("m_cnt_a",   {91'd0, count_a}, 96'(q.size()));
        chk("m_drop_a",  {80'd0, drop_a}, {80'd0, ea});
        chk("m_ovf_a",   {95'd0, ovf_a}, {95'd0, ovf});
        chk("m_v_b",     {95'd0, v_b},   {95'd0, q.size() > 0});
        chk("m_cnt_b",   {91'd0, count_b}, 96'(q.size()));
        chk("m_drop_b",  {94'd0, drop_b}, {94'd0, eb});
        chk("m_ovf_b",   {95'd0, ovf_b}, {95'd0, ovf});
        if (q.size() > 0) begin
            chk("m_data_a", data_a, q[0]);
            chk("m_data_b", data_b, q[0]);
        end
    endtask

    task automatic cycle(input logic e, input logic v, input logic [31:0] t,
                         input logic y, input logic c);
        logic acc;
        en = e; sv = v; tag = t; clr = c;
        yumi = y && (q.size() > 0);
        @(posedge clk);
        if (c) begin
            q.delete(); drops = 0; ovf = 0;
        end else begin
            acc = 1'b0;
            if (e && v) begin
                if (q.size() < 16 || yumi) acc = 1'b1;
                else begin drops++; ovf = 1; end
            end
            if (yumi) q.delete(0);
            if (acc) q.push_back({ctr, t});
        end
        #1;
        ctr = ctr + 64'd1;
        check_model();
    endtask

    initial begin
        int prob;
        rst_n = 1'b0; en = 0; clr = 0; sv = 0; yumi = 0; tag = '0; ctr = 64'd0;
        drops = 0; ovf = 0;
        #12;
        chk("rst_v",    {95'd0, v_a},    96'd0);
        chk("rst_cnt",  {91'd0, count_a}, 96'd0);
        chk("rst_drop", {80'd0, drop_a}, 96'd0);
        chk("rst_ovf",  {95'd0, ovf_a},  96'd0);
        #5 rst_n = 1'b1;

        // Basic capture/pop, enable gating and clear-vs-write priority.
        tbl[0] = mk(1, 1, 32'hA5, 0, 0, 1, 1, 0, 1, {64'd100, 32'hA5});
        tbl[1] = mk(1, 0, 32'h0,  1, 0, 0, 0, 0, 0, 96'd0);
        tbl[2] = mk(0, 1, 32'h11, 0, 0, 0, 0, 0, 0, 96'd0);
        tbl[3] = mk(0, 1, 32'h12, 0, 0, 0, 0, 0, 0, 96'd0);
        tbl[4] = mk(0, 1, 32'h13, 0, 0, 0, 0, 0, 0, 96'd0);
        tbl[5] = mk(0, 1, 32'h14, 0, 0, 0, 0, 0, 0, 96'd0);
        tbl[6] = mk(1, 1, 32'h77, 0, 1, 0, 0, 0, 0, 96'd0);
        tbl[7] = mk(1, 1, 32'h55, 0, 0, 1, 1, 0, 1, {64'd107, 32'h55});
        tbl[8] = mk(0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 96'd0);
        ctr = 64'd100;
        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].en, tbl[i].v, tbl[i].tag, tbl[i].y, tbl[i].clr);
            chk("tbl_v",    {95'd0, v_a},     {95'd0, tbl[i].exp_v});
            chk("tbl_cnt",  {91'd0, count_a}, {91'd0, tbl[i].exp_cnt});
            chk("tbl_drop", {80'd0, drop_a},  {80'd0, tbl[i].exp_drop});
            if (tbl[i].chk_data) chk("tbl_data", data_a, tbl[i].exp_data);
        end

        // Fill to full, overflow by three, drain in order.
        for (int i = 0; i < 16; i++) cycle(1, 1, 32'h200 + 32'(i), 0, 0);
        chk("t2_full_cnt", {91'd0, count_a}, 96'd16);
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h2F0 + 32'(i), 0, 0);
        chk("t2_drop", {80'd0, drop_a}, 96'd3);
        chk("t2_ovf",  {95'd0, ovf_a},  96'd1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", {64'd0, data_a[31:0]}, 96'(32'h200 + 32'(i)));
            cycle(0, 0, 0, 1, 0);
        end
        chk("t2_empty", {95'd0, v_a}, 96'd0);

        // Write and pop together while full.
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 1, 32'h300 + 32'(i), 0, 0);
        cycle(1, 1, 32'h3FF, 1, 0);
        chk("t3_cnt",  {91'd0, count_a}, 96'd16);
        chk("t3_drop", {80'd0, drop_a},  96'd0);
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", {64'd0, data_a[31:0]},
                (i < 15) ? 96'(32'h301 + 32'(i)) : 96'h3FF);
            cycle(0, 0, 0, 1, 0);
        end

        // Drop counter saturation on the 2-bit instance, then clear.
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) cycle(1, 1, 32'h400 + 32'(i), 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 32'h4F0, 0, 0);
        chk("t4_sat_b",  {94'd0, drop_b}, 96'd3);
        chk("t4_drop_a", {80'd0, drop_a}, 96'd5);
        cycle(0, 0, 0, 0, 1);
        chk("t4_clr_cnt",  {91'd0, count_b}, 96'd0);
        chk("t4_clr_drop", {94'd0, drop_b},  96'd0);
        chk("t4_clr_ovf",  {95'd0, ovf_b},   96'd0);
        chk("t4_clr_v",    {95'd0, v_b},     96'd0);

        // Asynchronous reset with entries buffered.
        for (int i = 0; i < 5; i++) cycle(1, 1, 32'h500 + 32'(i), 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_v_a",   {95'd0, v_a},     96'd0);
        chk("t6_rst_cnt_a", {91'd0, count_a}, 96'd0);
        chk("t6_rst_v_b",   {95'd0, v_b},     96'd0);
        chk("t6_rst_cnt_b", {91'd0, count_b}, 96'd0);
        q.delete(); drops = 0; ovf = 0;
        #2 rst_n = 1'b1;

        // Pointer wrap over 40 push/pop pairs.
        for (int i = 0; i < 3; i++) cycle(1, 1, 32'h600 + 32'(i), 0, 0);
        for (int i = 3; i < 43; i++) cycle(1, 1, 32'h600 + 32'(i), 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

        // Randomized traffic with shifting pop pressure.
        prob = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) prob = int'($urandom_range(10, 90));
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom,
                  int'($urandom_range(0, 99)) < prob, $urandom_range(0, 199) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
